boot_ram_loader: RTL and testbench
==================================

Name: boot_ram_loader

Overview:
- Parametrised boot/BIOS RAM for the 16-bit CPU memory map, successor to the fixed downloader-plus-RAM block.
- Runs on a single clock domain.
- After reset it accepts a byte-stream program image from the UART downloader, checks it with a trailing checksum, then serves the image as a Wishbone slave.
- Bus access is blocked until the load completes. A bad image locks the block into a FAIL state until reset.

Parameters:
- DATA_W, 16: Wishbone data width; must be a multiple of 8; NB = DATA_W/8 bytes per word.
- ADDR_W, 15: word-address width; DEPTH = 2**ADDR_W words, memory inferred internally.
- REGION_A, 4'h0: first 64 KB segment (wb_adr_i[19:16]) decoded by this RAM.
- REGION_B, 4'hF: second decoded segment (reset-vector segment).
- WP_AFTER_BOOT, 0: when 1, bus writes in RUN are acked but discarded (ROM behaviour).

Ports:
- wb_clk_i  in  1  sole clock
- wb_rst_n_i  in  1  reset, asynchronous assert, active-low
- ld_valid_i  in  1  downloader byte valid
- ld_ready_o  out  1  block accepts byte (high only in LOAD)
- ld_byte_i  in  8  image byte, little-endian within word
- ld_last_i  in  1  qualifies the checksum byte (final byte of stream)
- ld_done_o  out  1  image loaded and checksum good (RUN)
- ld_err_o  out  1  checksum or overflow failure (FAIL)
- wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  Wishbone classic cycle controls
- wb_adr_i  in  [19:1]  word address
- wb_sel_i  in  NB  byte lane selects
- wb_dat_i  in  DATA_W  write data
- wb_dat_o  out  DATA_W  read data, registered
- wb_ack_o  out  1  single-cycle acknowledge

Behaviour:
- Reset values (async): state=LOAD, byte index=0, word pointer=0, checksum=0, assembly register=0, wb_ack_o=0, wb_dat_o=0, ld_done_o=0, ld_err_o=0. Memory contents are not reset.
- States: LOAD -> CHECK -> RUN | FAIL. RUN and FAIL are exit-only by reset.
- LOAD:
  - ld_ready_o=1. A byte is accepted when ld_valid_i & ld_ready_o.
  - Every accepted byte is added to the 8-bit running sum, modulo 256.
  - A non-last byte goes into lane [byte index] of the assembly register, and byte index increments.
  - When the byte index reaches NB: the word is written to mem[word pointer] next edge, the pointer increments, the index clears, and the register clears.
  - Last byte: if the index is nonzero, the partial word (unfilled lanes = 0) is written first. The block then enters CHECK.
  - Overflow: a completed word with the word pointer already at DEPTH (pointer ADDR_W+1 bits wide) -> FAIL, no write.
- CHECK (1 cycle): sum == 8'h00 -> RUN, else -> FAIL. ld_ready_o=0.
- Bus decode: hit = wb_cyc_i & wb_stb_i & (wb_adr_i[19:16]==REGION_A | wb_adr_i[19:16]==REGION_B). Word index = wb_adr_i[ADDR_W:1].
  - Both segments alias the same memory.
  - Non-hit cycles are never acked.
- RUN bus access:
  - On hit & !wb_ack_o: perform the access this edge and assert wb_ack_o next cycle for exactly one cycle. The ack is deasserted the following cycle even if stb stays high. Throughput is one access per 2 cycles.
  - Read: wb_dat_o = mem[index], valid in the ack cycle and held until the next read.
  - Write: lanes with wb_sel_i[k]=1 are updated, unless WP_AFTER_BOOT=1. wb_sel_i=0 writes nothing but still acks.
- LOAD/CHECK bus access: hits are stalled (no ack). Master wait states are acceptable during boot.
- FAIL bus access: hits are acked. Reads return 0, writes are ignored. ld_err_o=1.
- Flags: ld_done_o=1 iff state==RUN. ld_err_o=1 iff state==FAIL.
- Reset mid-LOAD: all counters and the sum clear, and loading restarts at word 0. Partially written memory is simply overwritten by the new image.
- Downloader and bus activity in the same cycle cannot conflict, since they are gated by state. The single memory port is muxed by state.

Decomposition:
- Shared package boot_ram_pkg holds:
  - state enum {LOAD, CHECK, RUN, FAIL};
  - default region constants 4'h0 / 4'hF;
  - a function for byte-lane merge under sel.
- One natural sub-module, boot_ram_mem: single-port, byte-enable, synchronous-read RAM, parametrised by DATA_W/ADDR_W. It is kept separate so it can be swapped for a vendor BRAM macro.

Test Plan:
- Load bytes 34 12 78 56, then checksum EC with ld_last_i -> ld_done_o=1 after CHECK. Read adr 19'h00000 -> 16'h1234 with ack one cycle after stb. Read adr 19'h00001 -> 16'h5678. Read via segment F (adr 19'h78000) -> 16'h1234.
- Load 11 22 33, then checksum 9A -> RUN. Word 1 reads 16'h0033 (padded partial word).
- Load 34 12, then checksum 00 (bad) -> ld_err_o=1, ld_done_o=0. Bus read of word 0 is acked with 16'h0000. A further ld_valid_i is not accepted (ld_ready_o=0).
- After the good load, write word 0 with sel=2'b10, data 16'hABCD -> readback 16'hAB34. Repeat with WP_AFTER_BOOT=1 -> readback 16'h1234, write still acked.
- Issue a read during LOAD, and a read to segment 4'h5 in RUN -> no ack for 8 cycles. Hold stb high in RUN -> ack pattern 0,1,0,1.
- Assert wb_rst_n_i low after 3 of 5 bytes -> outputs return to reset values. Reload the full image -> correct readback. Stream DEPTH*NB+1 data bytes (ADDR_W=2) -> FAIL.

Source files
------------

// File: rtl/boot_ram_pkg.sv
// Shared types and helpers for the boot RAM loader.
//   state_t      : controller state, also exported on the debug port
//   REGION_*_DEF : default 64 KB segments decoded by the RAM
//   lane_merge() : byte-lane merge under a select mask. It operates on
//                  MERGE_W bits, so callers zero-extend narrower words
//                  into it and slice the result back out.
package boot_ram_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_CHECK = 2'd1,
    ST_RUN   = 2'd2,
    ST_FAIL  = 2'd3
  } state_t;

  localparam logic [3:0] REGION_A_DEF = 4'h0;
  localparam logic [3:0] REGION_B_DEF = 4'hF;

  // Widest data word the merge helper supports.
  localparam int MERGE_W = 64;

  // Lane k of the result comes from new_w when sel[k] is set, else from old_w.
  function automatic logic [MERGE_W-1:0] lane_merge(
    input logic [MERGE_W-1:0]   old_w,
    input logic [MERGE_W-1:0]   new_w,
    input logic [MERGE_W/8-1:0] sel
  );
    logic [MERGE_W-1:0] r;
    r = old_w;
    for (int k = 0; k < MERGE_W/8; k++) begin
      if (sel[k]) r[k*8 +: 8] = new_w[k*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/boot_ram_loader_if.sv
// Bundle of the downloader byte stream and the Wishbone classic slave bus.
// Signal names keep the block-level _i/_o suffixes as seen from the RAM.
//
// Downloader handshake: a byte moves on a rising clock edge where both
// ld_valid_i and ld_ready_o are high. ld_byte_i/ld_last_i must be stable
// while ld_valid_i is high. ld_last_i marks the checksum byte.
//
// Wishbone: classic single cycles. wb_ack_o is high for exactly one
// cycle per access.
//   master : the testbench / downloader + CPU side
//   slave  : the boot RAM
interface boot_ram_loader_if #(
  parameter int DATA_W = 16
);
  localparam int NB = DATA_W / 8;

  logic              ld_valid_i;
  logic              ld_ready_o;
  logic [7:0]        ld_byte_i;
  logic              ld_last_i;
  logic              ld_done_o;
  logic              ld_err_o;

  logic              wb_cyc_i;
  logic              wb_stb_i;
  logic              wb_we_i;
  logic [19:1]       wb_adr_i;
  logic [NB-1:0]     wb_sel_i;
  logic [DATA_W-1:0] wb_dat_i;
  logic [DATA_W-1:0] wb_dat_o;
  logic              wb_ack_o;

  modport master (
    output ld_valid_i, ld_byte_i, ld_last_i,
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    input  ld_ready_o, ld_done_o, ld_err_o, wb_dat_o, wb_ack_o
  );

  modport slave (
    input  ld_valid_i, ld_byte_i, ld_last_i,
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    output ld_ready_o, ld_done_o, ld_err_o, wb_dat_o, wb_ack_o
  );

endinterface

// File: rtl/boot_ram_mem.sv
// Single-port RAM with byte enables and a synchronous read port.
// Kept as its own module so it can be replaced by a vendor BRAM macro.
//   clk_i   : clock
//   en_i    : port enable (read or write this edge)
//   we_i    : write when set, read when clear
//   be_i    : byte enables for writes
//   addr_i  : word address
//   wdata_i : write data
//   rdata_o : read data, updated only by enabled reads (read data holds)
// Contents are not reset.
module boot_ram_mem #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 15
) (
  input  logic                clk_i,
  input  logic                en_i,
  input  logic                we_i,
  input  logic [DATA_W/8-1:0] be_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  output logic [DATA_W-1:0]   rdata_o
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int k = 0; k < NB; k++) begin
          if (be_i[k]) mem_q[addr_i][k*8 +: 8] <= wdata_i[k*8 +: 8];
        end
      end else begin
        rdata_o <= mem_q[addr_i];
      end
    end
  end

endmodule

// File: rtl/boot_ram_loader.sv
// Boot/BIOS RAM for the 16-bit CPU memory map.
// After reset it takes a little-endian byte image from the downloader,
// validates it with a trailing checksum byte (all bytes, checksum
// included, must sum to 0 mod 256), then serves it as a Wishbone slave.
// A bad checksum or an image larger than the RAM locks the block in
// FAIL until reset.
//   wb_clk_i   : sole clock
//   wb_rst_n_i : asynchronous active-low reset
//   bus        : downloader stream + Wishbone slave (boot_ram_loader_if.slave);
//                the interface DATA_W must match this module's DATA_W
//   state_o    : controller state, for debug/observation
// Parameters: DATA_W (multiple of 8, at most 64), ADDR_W (word address
// bits, at most 15), REGION_A/REGION_B (segments wb_adr_i[19:16] that
// alias onto the RAM), WP_AFTER_BOOT (writes in RUN acked but dropped).
module boot_ram_loader
  import boot_ram_pkg::*;
#(
  parameter int         DATA_W        = 16,
  parameter int         ADDR_W        = 15,
  parameter logic [3:0] REGION_A      = REGION_A_DEF,
  parameter logic [3:0] REGION_B      = REGION_B_DEF,
  parameter bit         WP_AFTER_BOOT = 1'b0
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_n_i,
  boot_ram_loader_if.slave   bus,
  output state_t             state_o
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [ADDR_W:0]     ptr_q, ptr_d;
  logic [DATA_W-1:0]   asm_q, asm_d;
  logic [7:0]          sum_q, sum_d;
  logic                ack_q, ack_d;
  // Selects the RAM read register onto wb_dat_o; clear gives zero data
  // (after reset, and for reads answered in FAIL).
  logic                rd_mem_q, rd_mem_d;

  logic                mem_en, mem_we;
  logic [NB-1:0]       mem_be;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata, mem_rdata;

  logic [3:0]          seg;
  logic                hit, accept, last_lane, ptr_full;
  logic [ADDR_W-1:0]   wb_idx;
  logic [NB-1:0]       byte_be;
  logic [DATA_W-1:0]   asm_with_byte;

  logic [MERGE_W-1:0]   m_old, m_new, m_res;
  logic [MERGE_W/8-1:0] m_sel;
  logic                 unused_bits;

  assign seg      = bus.wb_adr_i[19:16];
  assign wb_idx   = bus.wb_adr_i[ADDR_W:1];
  assign hit      = bus.wb_cyc_i & bus.wb_stb_i & ((seg == REGION_A) | (seg == REGION_B));
  assign accept   = bus.ld_valid_i & (state_q == ST_LOAD);
  assign last_lane = (idx_q == IDX_W'(NB - 1));
  // The pointer is one bit wider than the RAM index; its MSB means the
  // RAM is already full and any further word is an overflow.
  assign ptr_full = ptr_q[ADDR_W];
  assign byte_be  = NB'(1) << idx_q;

  // Assembly register with the incoming byte dropped into its lane.
  always_comb begin
    m_old = '0;
    m_new = '0;
    m_sel = '0;
    m_old[DATA_W-1:0] = asm_q;
    m_new[DATA_W-1:0] = {NB{bus.ld_byte_i}};
    m_sel[NB-1:0]     = byte_be;
    m_res = lane_merge(m_old, m_new, m_sel);
    asm_with_byte = m_res[DATA_W-1:0];
  end

  // Address bits above the RAM index and the merge headroom are not needed.
  assign unused_bits = ^{bus.wb_adr_i, m_res};

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    asm_d     = asm_q;
    sum_d     = sum_q;
    ack_d     = 1'b0;
    rd_mem_d  = rd_mem_q;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = ptr_q[ADDR_W-1:0];
    mem_wdata = asm_with_byte;

    case (state_q)
      ST_LOAD: begin
        if (accept) begin
          sum_d = sum_q + bus.ld_byte_i;
          if (!bus.ld_last_i) begin
            if (last_lane) begin
              // Word complete: commit it straight from the merged value.
              if (ptr_full) begin
                state_d = ST_FAIL;
              end else begin
                mem_en = 1'b1;
                mem_we = 1'b1;
                mem_be = '1;
                ptr_d  = ptr_q + (ADDR_W+1)'(1);
                idx_d  = '0;
                asm_d  = '0;
              end
            end else begin
              asm_d = asm_with_byte;
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            // The checksum byte is never stored; flush any partial word
            // (unfilled lanes are already zero).
            state_d = ST_CHECK;
            if (idx_q != '0) begin
              if (ptr_full) begin
                state_d = ST_FAIL;
              end else begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_be    = '1;
                mem_wdata = asm_q;
                ptr_d     = ptr_q + (ADDR_W+1)'(1);
                idx_d     = '0;
                asm_d     = '0;
              end
            end
          end
        end
      end

      ST_CHECK: begin
        state_d = (sum_q == 8'h00) ? ST_RUN : ST_FAIL;
      end

      ST_RUN: begin
        // The !ack_q term spaces accesses two cycles apart so a held
        // strobe sees a 0,1,0,1 ack pattern.
        if (hit && !ack_q) begin
          ack_d    = 1'b1;
          mem_en   = 1'b1;
          mem_addr = wb_idx;
          if (bus.wb_we_i) begin
            mem_we    = 1'b1;
            mem_be    = WP_AFTER_BOOT ? '0 : bus.wb_sel_i;
            mem_wdata = bus.wb_dat_i;
          end else begin
            rd_mem_d = 1'b1;
          end
        end
      end

      ST_FAIL: begin
        if (hit && !ack_q) begin
          ack_d = 1'b1;
          if (!bus.wb_we_i) rd_mem_d = 1'b0;
        end
      end

      default: state_d = ST_FAIL;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q  <= ST_LOAD;
      idx_q    <= '0;
      ptr_q    <= '0;
      asm_q    <= '0;
      sum_q    <= '0;
      ack_q    <= 1'b0;
      rd_mem_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      ptr_q    <= ptr_d;
      asm_q    <= asm_d;
      sum_q    <= sum_d;
      ack_q    <= ack_d;
      rd_mem_q <= rd_mem_d;
    end
  end

  boot_ram_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk_i   (wb_clk_i),
    .en_i    (mem_en),
    .we_i    (mem_we),
    .be_i    (mem_be),
    .addr_i  (mem_addr),
    .wdata_i (mem_wdata),
    .rdata_o (mem_rdata)
  );

  assign bus.ld_ready_o = (state_q == ST_LOAD);
  assign bus.ld_done_o  = (state_q == ST_RUN);
  assign bus.ld_err_o   = (state_q == ST_FAIL);
  assign bus.wb_ack_o   = ack_q;
  assign bus.wb_dat_o   = rd_mem_q ? mem_rdata : '0;
  assign state_o        = state_q;

endmodule

// File: tb/tb_boot_ram_loader.sv
// Directed bench for boot_ram_loader. Three instances share one stimulus
// stream: default (a), write-protected (w) and a 4-word RAM (s).
module tb_boot_ram_loader;
  import boot_ram_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_byte  = 8'h00;
  logic        ld_last  = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [19:1] adr  = '0;
  logic [1:0]  sel  = 2'b00;
  logic [15:0] wdat = 16'h0000;

  boot_ram_loader_if #(.DATA_W(16)) if_a ();
  boot_ram_loader_if #(.DATA_W(16)) if_w ();
  boot_ram_loader_if #(.DATA_W(16)) if_s ();

  assign if_a.ld_valid_i = ld_valid; assign if_w.ld_valid_i = ld_valid; assign if_s.ld_valid_i = ld_valid;
  assign if_a.ld_byte_i  = ld_byte;  assign if_w.ld_byte_i  = ld_byte;  assign if_s.ld_byte_i  = ld_byte;
  assign if_a.ld_last_i  = ld_last;  assign if_w.ld_last_i  = ld_last;  assign if_s.ld_last_i  = ld_last;
  assign if_a.wb_cyc_i   = cyc;      assign if_w.wb_cyc_i   = cyc;      assign if_s.wb_cyc_i   = cyc;
  assign if_a.wb_stb_i   = stb;      assign if_w.wb_stb_i   = stb;      assign if_s.wb_stb_i   = stb;
  assign if_a.wb_we_i    = we;       assign if_w.wb_we_i    = we;       assign if_s.wb_we_i    = we;
  assign if_a.wb_adr_i   = adr;      assign if_w.wb_adr_i   = adr;      assign if_s.wb_adr_i   = adr;
  assign if_a.wb_sel_i   = sel;      assign if_w.wb_sel_i   = sel;      assign if_s.wb_sel_i   = sel;
  assign if_a.wb_dat_i   = wdat;     assign if_w.wb_dat_i   = wdat;     assign if_s.wb_dat_i   = wdat;

  state_t st_a, st_w, st_s;

  boot_ram_loader dut_a (.wb_clk_i(clk), .wb_rst_n_i(rst_n), .bus(if_a), .state_o(st_a));
  boot_ram_loader #(.WP_AFTER_BOOT(1'b1)) dut_w (.wb_clk_i(clk), .wb_rst_n_i(rst_n), .bus(if_w), .state_o(st_w));
  boot_ram_loader #(.ADDR_W(2)) dut_s (.wb_clk_i(clk), .wb_rst_n_i(rst_n), .bus(if_s), .state_o(st_s));

  logic [2:0]  ack_w;
  logic [15:0] dat_w [3];
  assign ack_w    = {if_s.wb_ack_o, if_w.wb_ack_o, if_a.wb_ack_o};
  assign dat_w[0] = if_a.wb_dat_o;
  assign dat_w[1] = if_w.wb_dat_o;
  assign dat_w[2] = if_s.wb_dat_o;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    ld_valid = 1'b0; ld_last = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    #1;
    check("rst_ready", if_a.ld_ready_o, 1'b1);
    check("rst_done",  if_a.ld_done_o,  1'b0);
    check("rst_err",   if_a.ld_err_o,   1'b0);
    check("rst_ack",   if_a.wb_ack_o,   1'b0);
    check("rst_dat",   if_a.wb_dat_o,   16'h0000);
    check("rst_state", st_a,            ST_LOAD);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last, input logic exp_acc);
    logic acc;
    acc = 1'b0;
    ld_valid = 1'b1; ld_byte = b; ld_last = last;
    for (int i = 0; i < 4; i++) begin
      acc = if_a.ld_ready_o;
      @(posedge clk); #1;
      if (acc) break;
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    check("ld_accept", acc, exp_acc);
  endtask

  // Bytes packed little-endian: byte i is img[i*8 +: 8]; byte n-1 is the checksum.
  task automatic load_img(input logic [127:0] img, input int n);
    for (int i = 0; i < n; i++) send_byte(img[i*8 +: 8], (i == n-1), 1'b1);
  endtask

  logic [2:0]  got;
  logic [15:0] rdat [3];
  int          lat  [3];

  task automatic bus_access(input logic w, input logic [19:1] a, input logic [1:0] s,
                            input logic [15:0] d, input int max_cyc);
    got = 3'b000;
    for (int k = 0; k < 3; k++) begin rdat[k] = 16'hxxxx; lat[k] = -1; end
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; wdat = d;
    for (int c = 1; c <= max_cyc; c++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
        if (ack_w[k] && !got[k]) begin got[k] = 1'b1; rdat[k] = dat_w[k]; lat[k] = c; end
      end
      if (&got) break;
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  logic [3:0] ack_pat;

  initial begin
    #1;
    // Reset state and stalled boot read
    do_reset();
    bus_access(1'b0, 19'h00000, 2'b11, 16'h0, 8);
    check("load_read_noack", got, 3'b000);

    // Good 2-word image: 34 12 78 56, checksum EC
    load_img(128'hEC_56_78_12_34, 5);
    check("state_check", st_a, ST_CHECK);
    check("check_not_ready", if_a.ld_ready_o, 1'b0);
    @(posedge clk); #1;
    check("done_a", if_a.ld_done_o, 1'b1);
    check("err_a",  if_a.ld_err_o,  1'b0);
    check("done_w", if_w.ld_done_o, 1'b1);

    bus_access(1'b0, 19'h00000, 2'b11, 16'h0, 8);
    check("rd0_lat",  lat[0],  1);
    check("rd0_data", rdat[0], 16'h1234);
    bus_access(1'b0, 19'h00001, 2'b11, 16'h0, 8);
    check("rd1_data", rdat[0], 16'h5678);
    bus_access(1'b0, 19'h78000, 2'b11, 16'h0, 8);
    check("segF_data", rdat[0], 16'h1234);
    bus_access(1'b0, 19'h28000, 2'b11, 16'h0, 8);
    check("seg5_noack", got, 3'b000);

    // Byte-lane write; the write-protected instance still acks
    bus_access(1'b1, 19'h00000, 2'b10, 16'hABCD, 8);
    check("wr_ack_a",  got[0], 1'b1);
    check("wr_ack_wp", got[1], 1'b1);
    bus_access(1'b0, 19'h00000, 2'b11, 16'h0, 8);
    check("wr_rb_a",  rdat[0], 16'hAB34);
    check("wr_rb_wp", rdat[1], 16'h1234);
    // sel=0 write changes nothing but is acked
    bus_access(1'b1, 19'h00001, 2'b00, 16'hFFFF, 8);
    check("sel0_ack", got[0], 1'b1);
    bus_access(1'b0, 19'h00001, 2'b11, 16'h0, 8);
    check("sel0_rb", rdat[0], 16'h5678);

    // Held strobe: ack toggles 0,1,0,1
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 19'h00000;
    ack_pat[3] = if_a.wb_ack_o;
    for (int i = 2; i >= 0; i--) begin @(posedge clk); #1; ack_pat[i] = if_a.wb_ack_o; end
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    check("ack_pattern", ack_pat, 4'b0101);

    // Odd-length image, partial last word padded: 11 22 33, checksum 9A
    do_reset();
    load_img(128'h9A_33_22_11, 4);
    @(posedge clk); #1;
    check("odd_done", if_a.ld_done_o, 1'b1);
    bus_access(1'b0, 19'h00001, 2'b11, 16'h0, 8);
    check("odd_word1", rdat[0], 16'h0033);
    bus_access(1'b0, 19'h00000, 2'b11, 16'h0, 8);
    check("odd_word0", rdat[0], 16'h2211);

    // Bad checksum: 34 12, checksum 00
    do_reset();
    load_img(128'h00_12_34, 3);
    @(posedge clk); #1;
    check("bad_err",  if_a.ld_err_o,  1'b1);
    check("bad_done", if_a.ld_done_o, 1'b0);
    bus_access(1'b0, 19'h00000, 2'b11, 16'h0, 8);
    check("fail_ack",  got[0],  1'b1);
    check("fail_data", rdat[0], 16'h0000);
    check("fail_ready", if_a.ld_ready_o, 1'b0);
    send_byte(8'h55, 1'b0, 1'b0);

    // Reset after 3 of 5 bytes, then a full reload
    do_reset();
    send_byte(8'h34, 1'b0, 1'b1);
    send_byte(8'h12, 1'b0, 1'b1);
    send_byte(8'h78, 1'b0, 1'b1);
    do_reset();
    load_img(128'hEC_56_78_12_34, 5);
    @(posedge clk); #1;
    check("reload_done", if_a.ld_done_o, 1'b1);
    bus_access(1'b0, 19'h00000, 2'b11, 16'h0, 8);
    check("reload_w0", rdat[0], 16'h1234);
    bus_access(1'b0, 19'h00001, 2'b11, 16'h0, 8);
    check("reload_w1", rdat[0], 16'h5678);

    // 9 data bytes of 01 with a correct checksum F7: the 4-word RAM overflows
    do_reset();
    load_img(128'hF7_01_01_01_01_01_01_01_01_01, 10);
    @(posedge clk); #1;
    check("ovf_big_done",   if_a.ld_done_o, 1'b1);
    check("ovf_small_err",  if_s.ld_err_o,  1'b1);
    check("ovf_small_done", if_s.ld_done_o, 1'b0);
    bus_access(1'b0, 19'h00004, 2'b11, 16'h0, 8);
    check("ovf_big_w4",     rdat[0], 16'h0001);
    check("ovf_small_ack",  got[2],  1'b1);
    check("ovf_small_data", rdat[2], 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (%0d/%0d)", n_pass, n_checks);
    $fatal(1, "timeout");
  end

endmodule
